// File: rtl/fork_param_sync_pkg.sv
// Shared handshake definitions for the four-phase fork/join blocks.
// Holds the idle level of every handshake wire and the C-element update rule.
package fork_param_sync_pkg;

  localparam logic HS_IDLE = 1'b0;

  // Muller C-element rule: set on unanimous 1, clear on unanimous 0, else hold.
  function automatic logic c_elem_next(input logic all_one, input logic all_zero,
                                       input logic prev);
    logic res;
    if (all_one) begin
      res = 1'b1;
    end else if (all_zero) begin
      res = 1'b0;
    end else begin
      res = prev;
    end
    return res;
  endfunction

endpackage

// File: rtl/c_element_sync.sv
// Generic n-input clocked Muller C-element, output registered, reset to idle.
module c_element_sync
  import fork_param_sync_pkg::*;
#(
  parameter int n = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [n-1:0] a,
  output logic         c
);

  logic all_one_s;
  logic all_zero_s;
  logic c_next_s;
  logic c_r;

  assign all_one_s  = &a;
  assign all_zero_s = ~(|a);

  // Next output of the C-element from the current agreement of the inputs.
  always_comb begin
    c_next_s = c_elem_next(all_one_s, all_zero_s, c_r);
  end

  // Output register; cleared asynchronously so a reset mid-handshake restarts at idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c_r <= HS_IDLE;
    end else begin
      c_r <= c_next_s;
    end
  end

  assign c = c_r;

endmodule

// File: rtl/fork_param_sync.sv
// Clocked four-phase handshake fork: one request broadcast to size branches,
// upstream acknowledge is the C-element of all branch acknowledges.
module fork_param_sync
  import fork_param_sync_pkg::*;
#(
  parameter int size = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_in,
  output logic            ack_in,
  output logic [size-1:0] req_out,
  input  logic [size-1:0] ack_out
);

  logic [size-1:0] req_out_r;
  logic            ack_in_s;

  // Request broadcast register: every branch sees the same registered request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_out_r <= {size{HS_IDLE}};
    end else begin
      req_out_r <= {size{req_in}};
    end
  end

  c_element_sync #(
    .n (size)
  ) u_ack_join (
    .clk (clk),
    .rst (rst),
    .a   (ack_out),
    .c   (ack_in_s)
  );

  assign req_out = req_out_r;
  assign ack_in  = ack_in_s;

endmodule

// File: tb/tb_fork_param_sync.sv
// Self-checking bench for fork_param_sync (size = 2): reference model plus
// directed handshake sequences with hand-computed expectations.
module tb_fork_param_sync;

  localparam int SIZE = 2;

  logic            clk;
  logic            rst;
  logic            req_in;
  logic            ack_in;
  logic [SIZE-1:0] req_out;
  logic [SIZE-1:0] ack_out;

  int errors;
  int checks;
  bit chk_en;

  logic [SIZE-1:0] m_req;
  logic            m_ack;

  fork_param_sync #(.size(SIZE)) dut (
    .clk     (clk),
    .rst     (rst),
    .req_in  (req_in),
    .ack_in  (ack_in),
    .req_out (req_out),
    .ack_out (ack_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: branches copy last sampled request; ack rises on all-ones, falls on all-zeros.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_req <= '0;
      m_ack <= 1'b0;
    end else begin
      m_req <= req_in ? {SIZE{1'b1}} : {SIZE{1'b0}};
      if ($countones(ack_out) == SIZE)
        m_ack <= 1'b1;
      else if ($countones(ack_out) == 0)
        m_ack <= 1'b0;
      else
        m_ack <= m_ack;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_req_out", 32'(req_out), 32'(m_req));
      check("model_ack_in", 32'(ack_in), 32'(m_ack));
    end
  end

  task automatic step(input logic r, input logic [SIZE-1:0] a);
    @(negedge clk);
    req_in  = r;
    ack_out = a;
    @(negedge clk);
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    chk_en  = 1'b0;
    rst     = 1'b0;
    req_in  = 1'b1;
    ack_out = 2'b11;
    #1;
    check("reset_req_out", 32'(req_out), 32'h0);
    check("reset_ack_in", 32'(ack_in), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold_req_out", 32'(req_out), 32'h0);
    check("reset_hold_ack_in", 32'(ack_in), 32'h0);

    @(negedge clk);
    req_in  = 1'b0;
    ack_out = 2'b00;
    rst     = 1'b1;
    chk_en  = 1'b1;

    step(1'b0, 2'b00);
    check("idle_req_out", 32'(req_out), 32'h0);
    step(1'b1, 2'b00);
    check("broadcast_req_out", 32'(req_out), 32'h3);
    check("broadcast_ack_in", 32'(ack_in), 32'h0);
    step(1'b1, 2'b01);
    check("partial01_ack_in", 32'(ack_in), 32'h0);
    check("partial01_req_out", 32'(req_out), 32'h3);
    step(1'b1, 2'b10);
    check("partial10_ack_in", 32'(ack_in), 32'h0);
    check("partial10_req_out", 32'(req_out), 32'h3);
    step(1'b1, 2'b11);
    check("full_ack_in", 32'(ack_in), 32'h1);
    step(1'b1, 2'b10);
    check("hold10_ack_in", 32'(ack_in), 32'h1);
    step(1'b1, 2'b01);
    check("hold01_ack_in", 32'(ack_in), 32'h1);
    check("hold01_req_out", 32'(req_out), 32'h3);
    step(1'b1, 2'b00);
    check("release_ack_in", 32'(ack_in), 32'h0);
    step(1'b0, 2'b00);
    check("release_req_out", 32'(req_out), 32'h0);

    step(1'b1, 2'b11);
    check("pre_reset_ack_in", 32'(ack_in), 32'h1);
    check("pre_reset_req_out", 32'(req_out), 32'h3);
    #2;
    rst     = 1'b0;
    ack_out = 2'b01;
    #1;
    check("mid_reset_ack_in", 32'(ack_in), 32'h0);
    check("mid_reset_req_out", 32'(req_out), 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 2'b01);
    check("post_reset_ack_in", 32'(ack_in), 32'h0);
    check("post_reset_req_out", 32'(req_out), 32'h3);
    step(1'b1, 2'b01);
    check("post_reset_ack_hold0", 32'(ack_in), 32'h0);
    step(1'b1, 2'b11);
    check("recover_ack_in", 32'(ack_in), 32'h1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
